vending_fsm_param: RTL
======================

Name: vending_fsm_param

Overview:
Parametrised coin-operated vending controller, successor to the fixed two-coin vending FSM.
- Accepts 5/10/20-rupee coins with edge detection.
- Supports two products with parameter-set prices.
- Returns change and cancel refunds as a serial stream of 5-rupee pulses.
- Sits between coin-acceptor/keypad inputs and dispenser/coin-return actuators; the current/next state is exported for debug.

Parameters:
- CREDIT_W, 5: width of the credit register, in 5-rupee units.
- MAX_CREDIT, 20: highest credit accepted, in units (20 = 100 Rs). Must be < 2^CREDIT_W.
- PRICE_A, 3: price of item 0, in units. Range 1..MAX_CREDIT.
- PRICE_B, 4: price of item 1, in units. Range 1..MAX_CREDIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- coin_5  in  1  coin-acceptor level: 5 Rs coin present.
- coin_10  in  1  10 Rs coin present.
- coin_20  in  1  20 Rs coin present.
- sel  in  1  product select: 0 = item A, 1 = item B.
- cancel  in  1  level; requests a refund of the current credit.
- dispensed  out  1  one-cycle pulse: product released.
- item  out  1  latched selection of the current or last transaction.
- change  out  1  high for every cycle a coin is being returned.
- change_coin  out  1  one pulse per 5 Rs returned.
- refund  out  1  high while a cancel refund is in progress.
- coin_reject  out  1  one-cycle pulse: coin edge not credited.
- credit  out  CREDIT_W  current credit, in units.
- current  out  3  state register (debug).
- next  out  3  combinational next state (debug).

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; credit = 0; item = 0; refund flag = 0.
  - Coin history registers = 0. A coin held high through reset release therefore counts once, on the first clock after release.
  - All pulse outputs = 0.
- Coin edge detection:
  - rise_x = coin_x & ~coin_x_q; the history registers update every cycle in every state.
  - Values: coin_5 = 1 unit, coin_10 = 2 units, coin_20 = 4 units.
  - A held coin counts once.
  - Two or more rises in the same cycle: none credited; coin_reject = 1 for the next cycle.
- Acceptance: a coin is credited only in IDLE or COLLECT, without cancel, and only if credit + value <= MAX_CREDIT. Otherwise coin_reject pulses and credit is unchanged.
- State encoding: IDLE = 0, COLLECT = 1, VEND = 2, CHANGE = 3, REFUND = 4.
- IDLE:
  - credit = 0.
  - An accepted coin sets credit = value, latches item = sel, and moves to COLLECT.
  - sel is ignored at all other times.
  - cancel is ignored.
- COLLECT:
  - Let price = item ? PRICE_B : PRICE_A.
  - If credit >= price, go to VEND; coins arriving that cycle are rejected.
  - Else, if cancel, go to REFUND; a coin arriving that same cycle is rejected (cancel has priority).
  - Else, accept coins.
- VEND:
  - dispensed = 1 for exactly this one cycle.
  - credit <= credit - price.
  - Go to CHANGE if the remainder is > 0, else to IDLE.
- CHANGE and REFUND:
  - change = change_coin = 1 every cycle; credit decrements by 1 each cycle.
  - When credit == 1 in the current cycle, go to IDLE.
  - refund = 1 only in REFUND.
  - cancel and coins are ignored; coins are rejected.
- Latency, with the coin edge sampled at clock E0:
  - credit is updated at E0.
  - The price compare is made in the cycle after E0.
  - The machine enters VEND at E1; dispensed is high between E1 and E2.
  - The first change pulse occurs between E2 and E3.
  - Remainder r yields exactly r change_coin pulses on consecutive cycles.
- Output decoding:
  - dispensed, change, change_coin and refund are decoded from the registered state (Moore outputs).
  - coin_reject is registered.
  - next is the combinational next-state value.
- Reset mid-operation: outputs clear immediately, asynchronously; no further change pulses; the remaining credit is discarded.

Test Plan:
- Default params: reset pulse, then coin_5 and coin_10 each for one cycle with sel = 0. Required: credit goes 1 -> 3; dispensed pulses once; item = 0; zero change_coin pulses; returns to IDLE.
- sel = 1, then three separate coin_10 inserts. Required: after the second insert credit = 4 and the machine vends, so the third coin arrives in VEND/CHANGE. Then: dispensed once with item = 1; the third coin gets coin_reject; zero change pulses.
- sel = 0, single coin_20. Required: credit = 4; dispensed once; exactly 1 change_coin pulse; credit ends at 0.
- coin_10 held high for 5 cycles in IDLE. Required: credit = 2, credited once; no reject.
- coin_5, then coin_10 (credit 3, sel = 1), then cancel high for 1 cycle. Required: REFUND with refund = 1; exactly 3 consecutive change_coin pulses; dispensed never asserted.
- coin_5 and coin_10 rising in the same cycle. Required: coin_reject pulses; credit stays 0.
- Override MAX_CREDIT = 4 with PRICE_B = 4, sel = 1: coin_10 (credit 2), then coin_20. Required: coin_20 rejected (6 > 4); credit stays 2.
- From coin_20 with sel = 0, assert reset during CHANGE. Required: change and credit = 0 immediately; state = IDLE; no further pulses after release.

Source files
------------

// File: rtl/vending_fsm_param.sv
// Coin-operated vending controller: edge-detected 5/10/20 Rs coins, two
// parameter-priced products, change and cancel refunds as serial 5 Rs pulses.
module vending_fsm_param #(
    parameter int CREDIT_W   = 5,
    parameter int MAX_CREDIT = 20,
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                coin_20,
    input  logic                sel,
    input  logic                cancel,
    output logic                dispensed,
    output logic                item,
    output logic                change,
    output logic                change_coin,
    output logic                refund,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          current,
    output logic [2:0]          next
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VEND    = 3'd2,
        S_CHANGE  = 3'd3,
        S_REFUND  = 3'd4
    } state_t;

    localparam logic [CREDIT_W-1:0] P_A = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] P_B = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W:0]   P_MAX = (CREDIT_W+1)'(MAX_CREDIT);

    state_t                r_state, w_next;
    logic [CREDIT_W-1:0]   r_credit;
    logic                  r_item, r_c5_q, r_c10_q, r_c20_q;
    logic                  r_dispensed, r_change, r_refund, r_reject;

    logic                  w_rise5, w_rise10, w_rise20;
    logic [1:0]            w_nrise;
    logic                  w_single, w_multi;
    logic [CREDIT_W-1:0]   w_value, w_price;
    logic [CREDIT_W:0]     w_sum;
    logic                  w_paid, w_window, w_accept, w_reject;

    assign w_rise5  = coin_5  & ~r_c5_q;
    assign w_rise10 = coin_10 & ~r_c10_q;
    assign w_rise20 = coin_20 & ~r_c20_q;
    assign w_nrise  = {1'b0, w_rise5} + {1'b0, w_rise10} + {1'b0, w_rise20};
    assign w_single = (w_nrise == 2'd1);
    assign w_multi  = (w_nrise >= 2'd2);

    assign w_value = w_rise5  ? CREDIT_W'(1) :
                     w_rise10 ? CREDIT_W'(2) :
                     w_rise20 ? CREDIT_W'(4) : '0;
    assign w_price = r_item ? P_B : P_A;
    assign w_sum   = {1'b0, r_credit} + {1'b0, w_value};
    assign w_paid  = (r_credit >= w_price);

    // A paid-up or cancelling COLLECT refuses coins; IDLE ignores cancel.
    assign w_window = (r_state == S_IDLE) ||
                      ((r_state == S_COLLECT) && !w_paid && !cancel);
    assign w_accept = w_single && w_window && (w_sum <= P_MAX);
    assign w_reject = w_multi || (w_single && !w_accept);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_COLLECT;
            S_COLLECT: begin
                if (w_paid)      w_next = S_VEND;
                else if (cancel) w_next = S_REFUND;
            end
            S_VEND:    w_next = (r_credit != w_price) ? S_CHANGE : S_IDLE;
            S_CHANGE,
            S_REFUND:  if (r_credit == CREDIT_W'(1)) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_credit    <= '0;
            r_item      <= 1'b0;
            r_c5_q      <= 1'b0;
            r_c10_q     <= 1'b0;
            r_c20_q     <= 1'b0;
            r_dispensed <= 1'b0;
            r_change    <= 1'b0;
            r_refund    <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_c5_q      <= coin_5;
            r_c10_q     <= coin_10;
            r_c20_q     <= coin_20;
            r_state     <= w_next;
            r_reject    <= w_reject;
            // Moore outputs registered from the next state so they track r_state.
            r_dispensed <= (w_next == S_VEND);
            r_change    <= (w_next == S_CHANGE) || (w_next == S_REFUND);
            r_refund    <= (w_next == S_REFUND);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_credit <= w_value;
                        r_item   <= sel;
                    end else begin
                        r_credit <= '0;
                    end
                end
                S_COLLECT: if (w_accept) r_credit <= w_sum[CREDIT_W-1:0];
                S_VEND:    r_credit <= r_credit - w_price;
                S_CHANGE,
                S_REFUND:  r_credit <= r_credit - CREDIT_W'(1);
                default:   r_credit <= '0;
            endcase
        end
    end

    assign dispensed   = r_dispensed;
    assign item        = r_item;
    assign change      = r_change;
    assign change_coin = r_change;
    assign refund      = r_refund;
    assign coin_reject = r_reject;
    assign credit      = r_credit;
    assign current     = r_state;
    assign next        = w_next;

endmodule
